// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr, pred}
// entries with registered occupancy, one-cycle push-to-visible latency and flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_vld,
  input  logic [XLEN-1:0]          i_pc,
  input  logic [XLEN-1:0]          i_instr,
  input  logic                     i_pred,
  output logic                     o_rdy,
  output logic                     o_vld,
  output logic [XLEN-1:0]          o_pc_D,
  output logic [XLEN-1:0]          o_pc_four_D,
  output logic [XLEN-1:0]          o_instr_D,
  output logic                     o_pred_D,
  input  logic                     StallD,
  input  logic                     FlushD,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push, pop;

  always_comb begin
    // Ready depends only on the registered count, never on this cycle's pop.
    o_rdy = (cnt_q != CW'(DEPTH));
    o_vld = (cnt_q != '0);
    push  = i_vld && o_rdy && !FlushD;
    pop   = o_vld && !StallD && !FlushD;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (FlushD) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is live.
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) mem_q[wp_q] <= '{pc: i_pc, instr: i_instr, pred: i_pred};
  end

  always_comb begin
    head = mem_q[rp_q];
    if (o_vld) begin
      o_pc_D    = head.pc;
      o_instr_D = head.instr;
      o_pred_D  = head.pred;
    end else begin
      o_pc_D    = '0;
      o_instr_D = NOP;
      o_pred_D  = 1'b0;
    end
    o_pc_four_D = o_pc_D + XLEN'(4);
    o_count     = cnt_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scenarios plus random traffic against a queue-based reference model
// of the fetch queue.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic             i_clk = 1'b0;
  logic             i_rst, i_vld, i_pred, StallD, FlushD;
  logic [XLEN-1:0]  i_pc, i_instr;
  logic             o_rdy, o_vld, o_pred_D;
  logic [XLEN-1:0]  o_pc_D, o_pc_four_D, o_instr_D;
  logic [$clog2(DEPTH):0] o_count;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_pc(i_pc), .i_instr(i_instr),
    .i_pred(i_pred), .o_rdy(o_rdy), .o_vld(o_vld), .o_pc_D(o_pc_D),
    .o_pc_four_D(o_pc_four_D), .o_instr_D(o_instr_D), .o_pred_D(o_pred_D),
    .StallD(StallD), .FlushD(FlushD), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } ent_t;

  ent_t mq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a bounded FIFO; ready is judged on occupancy before the pop.
  task automatic model_edge();
    bit can_push, do_pop;
    ent_t e;
    if (i_rst || FlushD) begin
      mq.delete();
      return;
    end
    can_push = i_vld && (mq.size() < DEPTH);
    do_pop   = (mq.size() != 0) && !StallD;
    if (do_pop) void'(mq.pop_front());
    if (can_push) begin
      e.pc = i_pc; e.instr = i_instr; e.pred = i_pred;
      mq.push_back(e);
    end
  endtask

  task automatic check_all(input string tag);
    bit          ev;
    logic [31:0] epc, ein;
    logic        epr;
    ev  = mq.size() != 0;
    epc = ev ? mq[0].pc    : 32'h0;
    ein = ev ? mq[0].instr : 32'h0000_0013;
    epr = ev ? mq[0].pred  : 1'b0;
    chk({tag, ".count"}, 64'(o_count), 64'(mq.size()));
    chk({tag, ".rdy"},   64'(o_rdy),   64'(mq.size() < DEPTH));
    chk({tag, ".vld"},   64'(o_vld),   64'(ev));
    chk({tag, ".pc"},    64'(o_pc_D),  64'(epc));
    chk({tag, ".pc4"},   64'(o_pc_four_D), 64'(epc + 32'd4));
    chk({tag, ".instr"}, 64'(o_instr_D), 64'(ein));
    chk({tag, ".pred"},  64'(o_pred_D),  64'(epr));
  endtask

  task automatic cyc(input string tag, input logic rst, input logic vld, input logic [31:0] pc,
                     input logic stall, input logic flush);
    i_rst = rst; i_vld = vld; i_pc = pc; i_instr = $urandom; i_pred = 1'($urandom);
    StallD = stall; FlushD = flush;
    @(posedge i_clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    i_rst = 1'b1; i_vld = 1'b0; i_pc = '0; i_instr = '0; i_pred = 1'b0;
    StallD = 1'b0; FlushD = 1'b0;
    cyc("rst", 1, 0, 0, 0, 0);
    cyc("rst", 1, 1, 32'h40, 0, 0);
    chk("rst_rdy", 64'(o_rdy), 64'd1);
    chk("rst_pc4", 64'(o_pc_four_D), 64'd4);
    chk("rst_nop", 64'(o_instr_D), 64'h13);

    // fill with decode stalled; fifth push must be dropped
    for (int i = 0; i < 5; i++) cyc("fill", 0, 1, 32'(i * 4), 1, 0);
    chk("fill_cnt", 64'(o_count), 64'd4);
    chk("fill_rdy", 64'(o_rdy), 64'd0);
    chk("fill_pc",  64'(o_pc_D), 64'h0);

    // drain
    for (int i = 1; i < 4; i++) begin
      cyc("drain", 0, 0, 0, 0, 0);
      chk("drain_pc", 64'(o_pc_D), 64'(i * 4));
    end
    cyc("drain", 0, 0, 0, 0, 0);
    chk("drain_vld", 64'(o_vld), 64'd0);
    chk("drain_nop", 64'(o_instr_D), 64'h13);

    // streaming across pointer wrap
    cyc("strm", 0, 1, 32'h1000, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc("strm", 0, 1, 32'h1000 + 32'(i * 4), 0, 0);
      chk("strm_cnt", 64'(o_count), 64'd1);
      chk("strm_pc",  64'(o_pc_D), 64'(32'h1000 + 32'(i * 4)));
    end

    // flush with concurrent push
    cyc("pre", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("pre", 0, 1, 32'h200 + 32'(i * 4), 1, 0);
    chk("pre_cnt", 64'(o_count), 64'd3);
    cyc("flush", 0, 1, 32'h300, 0, 1);
    chk("flush_cnt", 64'(o_count), 64'd0);
    chk("flush_vld", 64'(o_vld), 64'd0);
    cyc("flush2", 0, 0, 0, 1, 0);
    chk("flush_absent", 64'(o_vld), 64'd0);

    // stall and flush together
    cyc("sf", 0, 1, 32'h400, 1, 0);
    cyc("sf", 0, 1, 32'h404, 1, 0);
    cyc("sf", 0, 1, 32'h408, 1, 1);
    chk("sf_cnt", 64'(o_count), 64'd0);

    // reset mid-operation with push and pop
    cyc("mr", 0, 1, 32'h500, 1, 0);
    cyc("mr", 0, 1, 32'h504, 1, 0);
    chk("mr_pre", 64'(o_count), 64'd2);
    cyc("mr", 1, 1, 32'h508, 0, 0);
    chk("mr_cnt", 64'(o_count), 64'd0);
    chk("mr_rdy", 64'(o_rdy), 64'd1);
    chk("mr_pc4", 64'(o_pc_four_D), 64'd4);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc("rnd", ($urandom_range(99) == 0), ($urandom_range(3) != 0), $urandom,
          ($urandom_range(2) == 0), ($urandom_range(24) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >= 2).
REQ-002 SHALL have parameter XLEN, default 32, PC and instruction width.
REQ-003 SHALL have port i_clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_vld, input, 1, fetch side presents a valid entry.
REQ-006 SHALL have port i_pc, input, XLEN, PC of fetched instruction.
REQ-007 SHALL have port i_instr, input, XLEN, fetched instruction word.
REQ-008 SHALL have port i_pred, input, 1, branch-predictor taken prediction for this PC.
REQ-009 SHALL have port o_rdy, output, 1, queue accepts an entry this cycle.
REQ-010 SHALL have port o_vld, output, 1, head entry valid toward decode.
REQ-011 SHALL have port o_pc_D, output, XLEN, head PC.
REQ-012 SHALL have port o_pc_four_D, output, XLEN, head PC + 4.
REQ-013 SHALL have port o_instr_D, output, XLEN, head instruction.
REQ-014 SHALL have port o_pred_D, output, 1, head prediction bit.
REQ-015 SHALL have port StallD, input, 1, decode holds; no pop.
REQ-016 SHALL have port FlushD, input, 1, mispredict/redirect; discard all entries.
REQ-017 SHALL have port o_count, output, clog2(DEPTH)+1, current occupancy.

Function
REQ-018 SHALL store entries {pc, instr, pred} in a circular buffer with write pointer wp, read pointer rp, each clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-019 SHALL drive o_rdy = (count != DEPTH), independent of StallD/FlushD (no combinational pop-to-ready path).
REQ-020 SHALL push when i_vld && o_rdy && !FlushD: write entry at wp, wp+1, count+1.
REQ-021 SHALL drive o_vld = (count != 0).
REQ-022 SHALL pop when o_vld && !StallD && !FlushD: rp+1, count-1.
REQ-023 SHALL, on simultaneous push and pop, update both pointers and leave count unchanged.
REQ-024 SHALL present head entry combinationally from storage at rp; o_pc_four_D = o_pc_D + 4, modulo 2^XLEN.
REQ-025 SHALL, when o_vld = 0, drive o_instr_D = 32'h0000_0013 (NOP), o_pc_D = 0, o_pc_four_D = 4, o_pred_D = 0.
REQ-026 SHALL give push-to-visible latency of one cycle (no bypass when empty).
REQ-027 SHALL, on FlushD = 1, set wp = rp = count = 0 at next edge, ignoring same-cycle push and pop; FlushD has priority over StallD.
REQ-028 SHALL ignore i_pc/i_instr/i_pred when push not taken; stored entries unchanged.
REQ-029 SHALL not change any stored entry or pointer while StallD = 1 and no push occurs.
REQ-030 SHALL keep o_count = count register exactly; count never exceeds DEPTH nor underflows.

Reset
REQ-031 SHALL, with i_rst = 1 at a rising edge, set wp = rp = count = 0; outputs then o_vld = 0, o_rdy = 1, o_count = 0, head outputs per REQ-025.
REQ-032 SHALL give i_rst priority over FlushD, push and pop; reset mid-operation discards all entries.
REQ-033 SHALL not require storage array contents to be reset.

Verification
REQ-034 SHALL cover fill: reset, push PCs 0x00,0x04,0x08,0x0C with StallD=1 -> count 4, o_rdy=0, fifth push ignored, o_pc_D=0x00.
REQ-035 SHALL cover drain: from full, StallD=0, i_vld=0 -> o_pc_D 0x00,0x04,0x08,0x0C on successive cycles, then o_vld=0, o_instr_D=0x00000013.
REQ-036 SHALL cover streaming: continuous push and pop for 10 cycles -> count constant at 1, output PCs in order, pointer wrap past DEPTH without loss.
REQ-037 SHALL cover flush: count 3, FlushD=1 with i_vld=1 -> next cycle count 0, o_vld=0, pushed entry absent.
REQ-038 SHALL cover stall-vs-flush priority: StallD=1 and FlushD=1 together -> queue emptied.
REQ-039 SHALL cover reset mid-operation: count 2, i_rst=1 with push+pop -> count 0, o_rdy=1, o_pc_four_D=4.
